// File: rtl/dmux8_way_pkg.sv
// ---------------------------------------------------------------------------
// dmux8_way_pkg
// Purpose : shared constants for the 4-way / 8-way demultiplexer slice.
//   DEFAULT_WIDTH : default data width of the routed input and every output
//   SEL4_W        : select width of the 4-way route (sel[1:0])
//   SEL8_W        : select width of the 8-way route (sel[2:0])
//   NUM_ROUTES    : total number of registered outputs (4 + 8)
// ---------------------------------------------------------------------------
package dmux8_way_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int SEL4_W        = 2;
  localparam int SEL8_W        = 3;
  localparam int NUM_ROUTES    = 12;

endpackage : dmux8_way_pkg

// File: rtl/dmux8_way_if.sv
// ---------------------------------------------------------------------------
// dmux8_way_if
// Purpose : bundles the data/select inputs and the twelve routed outputs of
//           dmux8_way into a single interface.
//   in             : data to be routed (WIDTH)
//   sel            : 3-bit select; sel[1:0] steers the 4-way route
//   a4..d4         : 4-way outputs for sel[1:0] = 0..3 (WIDTH each)
//   a8..h8         : 8-way outputs for sel = 0..7 (WIDTH each)
// Modports:
//   master : drives in/sel, observes the outputs (stimulus side)
//   slave  : receives in/sel, drives the outputs (the demultiplexer)
// ---------------------------------------------------------------------------
interface dmux8_way_if
  import dmux8_way_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]  in;
  logic [SEL8_W-1:0] sel;

  logic [WIDTH-1:0]  a4, b4, c4, d4;
  logic [WIDTH-1:0]  a8, b8, c8, d8, e8, f8, g8, h8;

  modport master (
    output in, sel,
    input  a4, b4, c4, d4,
    input  a8, b8, c8, d8, e8, f8, g8, h8
  );

  modport slave (
    input  in, sel,
    output a4, b4, c4, d4,
    output a8, b8, c8, d8, e8, f8, g8, h8
  );

endinterface : dmux8_way_if

// File: rtl/dmux8_way_dmux4_way.sv
// ---------------------------------------------------------------------------
// dmux4_way
// Purpose : purely combinational 1-to-4 demultiplexer. The selected output
//           carries in_i; the other three are all-zero.
//   in_i  : data to route (WIDTH)
//   sel_i : 2-bit select
//   a_o   : in_i when sel_i = 0, else zero
//   b_o   : in_i when sel_i = 1, else zero
//   c_o   : in_i when sel_i = 2, else zero
//   d_o   : in_i when sel_i = 3, else zero
// ---------------------------------------------------------------------------
module dmux4_way
  import dmux8_way_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]  in_i,
  input  logic [SEL4_W-1:0] sel_i,
  output logic [WIDTH-1:0]  a_o,
  output logic [WIDTH-1:0]  b_o,
  output logic [WIDTH-1:0]  c_o,
  output logic [WIDTH-1:0]  d_o
);

  always_comb begin
    a_o = '0;
    b_o = '0;
    c_o = '0;
    d_o = '0;
    case (sel_i)
      2'd0:    a_o = in_i;
      2'd1:    b_o = in_i;
      2'd2:    c_o = in_i;
      default: d_o = in_i;
    endcase
  end

endmodule : dmux4_way

// File: rtl/dmux8_way.sv
// ---------------------------------------------------------------------------
// dmux8_way
// Purpose : registered 4-way and 8-way demultiplexer sharing one data input
//           and one select. Both routes are computed every cycle and the
//           twelve results are captured in a single register stage, so every
//           output lags its in/sel sample by exactly one clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears all outputs immediately
//   bus   : dmux8_way_if slave modport (in, sel, a4..d4, a8..h8)
// ---------------------------------------------------------------------------
module dmux8_way
  import dmux8_way_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  dmux8_way_if.slave   bus
);

  logic [WIDTH-1:0] a4_d, b4_d, c4_d, d4_d;
  logic [WIDTH-1:0] a8_d, b8_d, c8_d, d8_d, e8_d, f8_d, g8_d, h8_d;
  logic [WIDTH-1:0] lo_in, hi_in;

  logic [NUM_ROUTES-1:0][WIDTH-1:0] route_d;
  logic [NUM_ROUTES-1:0][WIDTH-1:0] route_q;

  // 4-way route ignores sel[2] entirely.
  dmux4_way #(.WIDTH(WIDTH)) u_route4 (
    .in_i  (bus.in),
    .sel_i (bus.sel[SEL4_W-1:0]),
    .a_o   (a4_d),
    .b_o   (b4_d),
    .c_o   (c4_d),
    .d_o   (d4_d)
  );

  // sel[2] gates the data into exactly one half of the 8-way route; the idle
  // half sees zero data and therefore drives all-zero on every output.
  assign lo_in = bus.sel[SEL8_W-1] ? '0 : bus.in;
  assign hi_in = bus.sel[SEL8_W-1] ? bus.in : '0;

  dmux4_way #(.WIDTH(WIDTH)) u_route8_lo (
    .in_i  (lo_in),
    .sel_i (bus.sel[SEL4_W-1:0]),
    .a_o   (a8_d),
    .b_o   (b8_d),
    .c_o   (c8_d),
    .d_o   (d8_d)
  );

  dmux4_way #(.WIDTH(WIDTH)) u_route8_hi (
    .in_i  (hi_in),
    .sel_i (bus.sel[SEL4_W-1:0]),
    .a_o   (e8_d),
    .b_o   (f8_d),
    .c_o   (g8_d),
    .d_o   (h8_d)
  );

  assign route_d = {a4_d, b4_d, c4_d, d4_d,
                    a8_d, b8_d, c8_d, d8_d, e8_d, f8_d, g8_d, h8_d};

  // Single output stage; no enable, so every edge out of reset reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_q <= '0;
    end else begin
      route_q <= route_d;
    end
  end

  assign {bus.a4, bus.b4, bus.c4, bus.d4,
          bus.a8, bus.b8, bus.c8, bus.d8,
          bus.e8, bus.f8, bus.g8, bus.h8} = route_q;

endmodule : dmux8_way

// File: tb/tb_dmux8_way.sv
// ---------------------------------------------------------------------------
// tb_dmux8_way
// Purpose : self-checking bench for dmux8_way. Two instances share clk,
//           rst_n and sel: one at WIDTH = 1 and one at WIDTH = 8. Expected
//           output sets are built from hand-written one-hot flag tables and
//           queued when stimulus is driven, then popped one cycle later.
// ---------------------------------------------------------------------------
module tb_dmux8_way;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int failures = 0;

  dmux8_way_if #(.WIDTH(1)) bus1 ();
  dmux8_way_if #(.WIDTH(8)) bus8 ();

  dmux8_way #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  dmux8_way #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  always #5 clk = ~clk;

  // One stimulus row: inputs plus the one-hot position of the active output
  // in each route (a4 / a8 are the most significant flag bits).
  typedef struct {
    logic       in1;
    logic [7:0] in8;
    logic [2:0] sel;
    logic [3:0] f4;
    logic [7:0] f8;
  } vec_t;

  // Expected outputs, ordered a4,b4,c4,d4,a8..h8 from index 11 down to 0.
  typedef struct {
    logic [11:0]      e1;
    logic [11:0][7:0] e8;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t lastExp;

  function automatic vec_t mkVec(logic in1, logic [7:0] in8, logic [2:0] sel,
                                 logic [3:0] f4, logic [7:0] f8);
    vec_t v;
    v.in1 = in1;
    v.in8 = in8;
    v.sel = sel;
    v.f4  = f4;
    v.f8  = f8;
    return v;
  endfunction

  function automatic exp_t makeExp(logic in1, logic [7:0] in8,
                                   logic [3:0] f4, logic [7:0] f8);
    exp_t r;
    logic [11:0] flags;
    flags = {f4, f8};
    r.e1 = flags & {12{in1}};
    for (int j = 0; j < 12; j++) begin
      r.e8[j] = flags[j] ? in8 : 8'h00;
    end
    return r;
  endfunction

  function automatic logic [11:0] act1();
    return {bus1.a4, bus1.b4, bus1.c4, bus1.d4,
            bus1.a8, bus1.b8, bus1.c8, bus1.d8,
            bus1.e8, bus1.f8, bus1.g8, bus1.h8};
  endfunction

  function automatic logic [11:0][7:0] act8();
    return {bus8.a4, bus8.b4, bus8.c4, bus8.d4,
            bus8.a8, bus8.b8, bus8.c8, bus8.d8,
            bus8.e8, bus8.f8, bus8.g8, bus8.h8};
  endfunction

  task automatic compareBoth(input string name, input exp_t e);
    logic [11:0]      a1;
    logic [11:0][7:0] a8;
    a1 = act1();
    a8 = act8();
    checks++;
    if (a1 !== e.e1) begin
      failures++;
      $display("[TB] FAIL %s w1: actual=%b required=%b", name, a1, e.e1);
    end
    checks++;
    if (a8 !== e.e8) begin
      failures++;
      $display("[TB] FAIL %s w8: actual=%h required=%h", name, a8, e.e8);
    end
  endtask

  // Drive on the falling edge, queue the expectation, then step to just past
  // the next rising edge where the result should be visible.
  task automatic applyStimulus(input logic in1, input logic [7:0] in8,
                               input logic [2:0] sel,
                               input logic [3:0] f4, input logic [7:0] f8);
    @(negedge clk);
    bus1.in  = in1;
    bus1.sel = sel;
    bus8.in  = in8;
    bus8.sel = sel;
    sb.push_back(makeExp(in1, in8, f4, f8));
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, actual=0 entries required=1", name);
    end else begin
      lastExp = sb.pop_front();
      compareBoth(name, lastExp);
    end
  endtask

  initial begin
    exp_t zero;
    zero = makeExp(1'b0, 8'h00, 4'b0000, 8'h00);

    // in = 0 sweep: every output must stay zero whatever sel is.
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd0, 4'b1000, 8'b1000_0000));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd1, 4'b0100, 8'b0100_0000));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd2, 4'b0010, 8'b0010_0000));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd3, 4'b0001, 8'b0001_0000));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd4, 4'b1000, 8'b0000_1000));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd5, 4'b0100, 8'b0000_0100));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd6, 4'b0010, 8'b0000_0010));
    vecs.push_back(mkVec(1'b0, 8'h00, 3'd7, 4'b0001, 8'b0000_0001));
    // in = 1 sweep, including the 7 -> 0 wrap at the end.
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd0, 4'b1000, 8'b1000_0000));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd1, 4'b0100, 8'b0100_0000));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd2, 4'b0010, 8'b0010_0000));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd3, 4'b0001, 8'b0001_0000));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd4, 4'b1000, 8'b0000_1000));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd5, 4'b0100, 8'b0000_0100));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd6, 4'b0010, 8'b0000_0010));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd7, 4'b0001, 8'b0000_0001));
    vecs.push_back(mkVec(1'b1, 8'h3C, 3'd0, 4'b1000, 8'b1000_0000));
    // Wide data to g8/c4, mixed widths, and 3 -> 4 half crossing.
    vecs.push_back(mkVec(1'b1, 8'hA5, 3'd6, 4'b0010, 8'b0000_0010));
    vecs.push_back(mkVec(1'b0, 8'h5A, 3'd2, 4'b0010, 8'b0010_0000));
    vecs.push_back(mkVec(1'b1, 8'hC3, 3'd3, 4'b0001, 8'b0001_0000));
    vecs.push_back(mkVec(1'b1, 8'h81, 3'd4, 4'b1000, 8'b0000_1000));

    // Asynchronous reset with live inputs and no clock edge yet.
    bus1.in  = 1'b1;
    bus1.sel = 3'd5;
    bus8.in  = 8'hFF;
    bus8.sel = 3'd5;
    #1 rst_n = 1'b0;
    #2 compareBoth("rst_no_edge", zero);

    // Clock edges during reset must be ignored.
    repeat (2) @(posedge clk);
    #1 compareBoth("rst_hold", zero);

    // First edge after release loads the routed sample (sel = 5 -> f8 / b4).
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hFF, 3'd5, 4'b0100, 8'b0000_0100);
    checkOutput("first_after_rst");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in1, vecs[i].in8, vecs[i].sel, vecs[i].f4, vecs[i].f8);
      checkOutput($sformatf("vec%0d_sel%0d", i, vecs[i].sel));
    end

    // Input changes between edges must not reach the outputs.
    applyStimulus(1'b1, 8'h77, 3'd1, 4'b0100, 8'b0100_0000);
    checkOutput("hold_pre");
    #2;
    bus1.in  = 1'b0;
    bus1.sel = 3'd6;
    bus8.in  = 8'h11;
    bus8.sel = 3'd6;
    #2 compareBoth("hold_between_edges", lastExp);

    // Reset pulse in the middle of a sweep clears at once, then resumes.
    applyStimulus(1'b1, 8'h0F, 3'd0, 4'b1000, 8'b1000_0000);
    checkOutput("sweep_sel0");
    applyStimulus(1'b1, 8'h0F, 3'd1, 4'b0100, 8'b0100_0000);
    checkOutput("sweep_sel1");
    applyStimulus(1'b1, 8'h0F, 3'd2, 4'b0010, 8'b0010_0000);
    checkOutput("sweep_sel2");
    #2 rst_n = 1'b0;
    #1 compareBoth("rst_mid_sweep", zero);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h0F, 3'd3, 4'b0001, 8'b0001_0000);
    checkOutput("after_mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_dmux8_way
